// File: rtl/pulse_arbiter_if.sv
// ----------------------------------------------------------------------------
// pulse_arbiter_if
// Event channel between pulse_arbiter and its downstream consumer.
//   out_valid : event offered (arbiter -> consumer)
//   out_id    : channel index of the offered event (arbiter -> consumer)
//   out_ready : consumer accepts the offered event (consumer -> arbiter)
// Modports: master = arbiter side, slave = consumer side.
// ----------------------------------------------------------------------------
interface pulse_arbiter_if #(
    parameter int IDW = 2
);
    logic           out_valid;
    logic [IDW-1:0] out_id;
    logic           out_ready;

    modport master (
        output out_valid,
        output out_id,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_id,
        output out_ready
    );
endinterface

// File: rtl/pulse_arbiter.sv
// ----------------------------------------------------------------------------
// pulse_arbiter
// Synchronises N asynchronous level inputs (2-FF), detects rising edges,
// latches them as pending requests and serialises them round-robin onto a
// single valid/ready event channel carrying the source channel id.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high
//   bi       in   N asynchronous level inputs
//   evt      if   event channel (master): out_valid, out_id, out_ready
//   pending  out  registered pending-request flags
//   busy     out  high while the FSM is in OFFER or GAP
//
// Optional feature (macro PULSE_ARBITER_OVERRUN_EN):
//   ovr_clr  in   clears all overrun flags (a new overrun in the same cycle wins)
//   overrun  out  sticky per-channel flag: edge arrived while already pending
// ----------------------------------------------------------------------------
module pulse_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   bi,
    pulse_arbiter_if.master evt,
    output logic [N-1:0]   pending,
    output logic           busy
`ifdef PULSE_ARBITER_OVERRUN_EN
    ,
    input  logic           ovr_clr,
    output logic [N-1:0]   overrun
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_GAP
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [N-1:0]   r_sync1;
    logic [N-1:0]   r_sync2;
    logic [N-1:0]   r_prev;
    logic [N-1:0]   r_pending;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_out_id;
    logic           r_out_valid;

    logic [N-1:0]   w_edge;
    logic [N-1:0]   w_clr;
    logic           w_found;
    logic [IDW-1:0] w_sel_id;
    logic [IDW-1:0] w_ptr_next;
    logic [IDW-1:0] w_id_next;
    logic           w_valid_next;

    // ------------------------------------------------------------------
    // Front end: 2-FF synchroniser plus one history stage for edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= bi;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_prev;

    // Pending flags: a new edge overrides the clear from an acceptance in the
    // same cycle, so a fresh request is never lost to the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first pending bit scanning ptr, ptr+1, ... mod N
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_sel_id = '0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && r_pending[idx]) begin
                w_found  = 1'b1;
                w_sel_id = IDW'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register and registered channel outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_out_id    <= w_id_next;
            r_out_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_id_next    = r_out_id;
        w_valid_next = r_out_valid;
        w_clr        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_id_next    = w_sel_id;
                    w_valid_next = 1'b1;
                    w_state_next = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Offer is held indefinitely until accepted; no re-arbitration.
                if (evt.out_ready) begin
                    w_clr[r_out_id] = 1'b1;
                    if (r_out_id == IDW'(N - 1)) begin
                        w_ptr_next = '0;
                    end else begin
                        w_ptr_next = r_out_id + 1'b1;
                    end
                    w_valid_next = 1'b0;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_valid_next = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign evt.out_valid = r_out_valid;
    assign evt.out_id    = r_out_id;
    assign pending       = r_pending;
    assign busy          = (r_state != ST_IDLE);

`ifdef PULSE_ARBITER_OVERRUN_EN
    logic [N-1:0] r_overrun;

    // An edge merged into an already-pending, not-being-cleared request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= '0;
        end else begin
            r_overrun <= (r_overrun & ~{N{ovr_clr}}) | (w_edge & r_pending & ~w_clr);
        end
    end

    assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_pulse_arbiter.sv
module tb_pulse_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   bi;
    logic [N-1:0]   pending;
    logic           busy;
`ifdef PULSE_ARBITER_OVERRUN_EN
    logic           ovr_clr;
    logic [N-1:0]   overrun;
`endif

    pulse_arbiter_if #(.IDW(IDW)) evt ();

    pulse_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bi      (bi),
        .evt     (evt),
        .pending (pending),
        .busy    (busy)
`ifdef PULSE_ARBITER_OVERRUN_EN
        ,
        .ovr_clr (ovr_clr),
        .overrun (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compare_cnt  = 0;
    int mismatch_cnt = 0;
    int hs_count     = 0;
    int cyc          = 0;
    int base;
    logic [IDW-1:0] sb_q[$];
    int             hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compare_cnt++;
        assert (obs === exp) else begin
            mismatch_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: a handshake happens at the posedge following a negedge that
    // sees valid & ready (inputs only change just after posedges).
    always @(negedge clk) begin
        if (!rst && evt.out_valid === 1'b1 && evt.out_ready === 1'b1) begin
            logic [IDW-1:0] exp_id;
            hs_count++;
            hs_cyc.push_back(cyc);
            compare_cnt++;
            assert (sb_q.size() > 0) else begin
                mismatch_cnt++;
                $error("FAIL unexpected_evt: observed id=%0d expected=no event", evt.out_id);
            end
            if (sb_q.size() > 0) begin
                exp_id = sb_q.pop_front();
                check("evt_id", 32'(evt.out_id), 32'(exp_id));
                $display("event id=%0d at cycle %0d", evt.out_id, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_hs(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (hs_count < target && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(hs_count), 32'(target));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (evt.out_valid !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(evt.out_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bi  = '0;
        evt.out_ready = 1'b0;
`ifdef PULSE_ARBITER_OVERRUN_EN
        ovr_clr = 1'b0;
`endif

        // ---------------- reset with all inputs high ----------------
        bi = 4'b1111;
        evt.out_ready = 1'b1;
        tick(2);
        check("rst_valid",   32'(evt.out_valid), 32'd0);
        check("rst_id",      32'(evt.out_id),    32'd0);
        check("rst_pending", 32'(pending),       32'd0);
        check("rst_busy",    32'(busy),          32'd0);
        sb_q.push_back(2'd0); sb_q.push_back(2'd1);
        sb_q.push_back(2'd2); sb_q.push_back(2'd3);
        base = hs_count;
        rst = 1'b0;
        tick(1);
        check("rst_release_v1", 32'(evt.out_valid), 32'd0);
        tick(1);
        check("rst_release_v2", 32'(evt.out_valid), 32'd0);
        tick(1);
        check("rst_pending_all", 32'(pending), 32'hF);
        tick(1);
        check("rst_first_valid", 32'(evt.out_valid), 32'd1);
        check("rst_first_id",    32'(evt.out_id),    32'd0);
        wait_hs("rst_drain", base + 4, 40);
        bi = '0;
        tick(5);

        // ---------------- single event ----------------
        sb_q.push_back(2'd2);
        base = hs_count;
        bi[2] = 1'b1;
        tick(3);
        check("single_pending_P2", 32'(pending), 32'h4);
        check("single_valid_P2",   32'(evt.out_valid), 32'd0);
        tick(1);
        check("single_valid_P3", 32'(evt.out_valid), 32'd1);
        check("single_id_P3",    32'(evt.out_id),    32'd2);
        check("single_busy_P3",  32'(busy),          32'd1);
        tick(1);
        check("single_valid_P4",   32'(evt.out_valid), 32'd0);
        check("single_pending_P4", 32'(pending[2]),    32'd0);
        check("single_busy_P4",    32'(busy),          32'd1);
        tick(1);
        check("single_busy_P5", 32'(busy), 32'd0);
        tick(10);
        check("single_once", 32'(hs_count), 32'(base + 1));
        bi = '0;
        tick(4);

        // ---------------- round-robin ----------------
        do_reset();
        hs_cyc.delete();
        sb_q.push_back(2'd1); sb_q.push_back(2'd3); sb_q.push_back(2'd0);
        base = hs_count;
        bi[1] = 1'b1;
        bi[3] = 1'b1;
        wait_hs("rr_first", base + 1, 20);
        bi[0] = 1'b1;
        wait_hs("rr_all", base + 3, 30);
        if (hs_cyc.size() >= 3) begin
            check("rr_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
            check("rr_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
        end
        bi = '0;
        tick(4);

        // ---------------- backpressure ----------------
        do_reset();
        evt.out_ready = 1'b0;
        bi = 4'b0011;
        wait_valid("bp_offer", 10);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", 32'(evt.out_valid), 32'd1);
            check("bp_hold_id",    32'(evt.out_id),    32'd0);
            tick(1);
        end
        hs_cyc.delete();
        sb_q.push_back(2'd0); sb_q.push_back(2'd1);
        base = hs_count;
        evt.out_ready = 1'b1;
        wait_hs("bp_drain", base + 2, 20);
        if (hs_cyc.size() >= 2) begin
            check("bp_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
        end
        bi = '0;
        tick(4);

        // ---------------- set-wins race ----------------
        do_reset();
        evt.out_ready = 1'b0;
        bi[3] = 1'b1;
        wait_valid("sw_offer", 10);
        check("sw_id", 32'(evt.out_id), 32'd3);
        bi[3] = 1'b0;
        tick(4);
        sb_q.push_back(2'd3); sb_q.push_back(2'd3);
        base = hs_count;
        bi[3] = 1'b1;
        tick(2);
        evt.out_ready = 1'b1;
        tick(1);
        check("sw_pending_kept", 32'(pending[3]), 32'd1);
        wait_hs("sw_second", base + 2, 20);
        bi = '0;
        tick(4);

`ifdef PULSE_ARBITER_OVERRUN_EN
        // ---------------- overrun ----------------
        do_reset();
        evt.out_ready = 1'b0;
        bi[1] = 1'b1;
        tick(3);
        bi[1] = 1'b0;
        tick(3);
        bi[1] = 1'b1;
        tick(5);
        check("ovr_flag",  32'(overrun),       32'h2);
        check("ovr_offer", 32'(evt.out_id),    32'd1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);
        sb_q.push_back(2'd1);
        base = hs_count;
        evt.out_ready = 1'b1;
        wait_hs("ovr_one_evt", base + 1, 10);
        tick(10);
        check("ovr_only_one", 32'(hs_count), 32'(base + 1));
        bi = '0;
        tick(4);
`endif

        // ---------------- mid-offer reset ----------------
        evt.out_ready = 1'b0;
        bi = 4'b0101;
        wait_valid("mr_offer", 10);
        rst = 1'b1;
        bi  = '0;
        tick(1);
        rst = 1'b0;
        check("mr_valid",   32'(evt.out_valid), 32'd0);
        check("mr_pending", 32'(pending),       32'd0);
        check("mr_busy",    32'(busy),          32'd0);
        base = hs_count;
        evt.out_ready = 1'b1;
        tick(15);
        check("mr_no_event", 32'(hs_count), 32'(base));

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end
endmodule
